// File: rtl/life_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the life array sequencer: FSM encoding, preset patterns, scan length.
// Latency: n/a (types, constants and a pure combinational decode helper).
// Backpressure: n/a.
package life_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_ARMED   = 3'd2,
      ST_ADVANCE = 3'd3,
      ST_SCAN    = 3'd4
   } state_t;

   localparam logic [15:0] PRESET_0 = 16'h3300;
   localparam logic [15:0] PRESET_1 = 16'h33CC;
   localparam logic [15:0] PRESET_2 = 16'h0600;
   localparam logic [15:0] PRESET_3 = 16'h6286;

   // One scan pulse per cell of the 4x4 array.
   localparam int SCAN_LEN_DEF = 16;

   // Priority decode of the preset selector, bit0 wins.
   function automatic logic [15:0] preset_val(input logic [3:0] sel);
      logic [15:0] v;
      if (sel[0])      v = PRESET_0;
      else if (sel[1]) v = PRESET_1;
      else if (sel[2]) v = PRESET_2;
      else if (sel[3]) v = PRESET_3;
      else             v = 16'h0000;
      return v;
   endfunction

endpackage

// File: rtl/life_tick_timer.sv
`timescale 1ns/1ps
// Free-running tick generator: counts 0..TICK_MAX-1 and flags the last count.
// Latency: tick is high for the one cycle the counter sits at TICK_MAX-1.
// Backpressure: none; clr restarts the count from zero on the next edge.
module life_tick_timer #(
   parameter int TICK_MAX = 100000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W    = $clog2(TICK_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wrap at the last value, restart on clear.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/life_sequencer.sv
`timescale 1ns/1ps
// Sequencer for the 4x4 life array: preset loads, frame-aligned generation steps, scan bursts.
// Latency: strobes are registered, one cycle after the request/frame edge is sampled.
// Backpressure: one pending advance is queued while busy; further dropped requests set overrun.
module life_sequencer
   import life_sequencer_pkg::*;
#(
   parameter int TICK_MAX = 100000000,
   parameter int SCAN_LEN = SCAN_LEN_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  selector,
   input  logic        load_req,
   input  logic        step_req,
   input  logic        run_enb,
   input  logic        scan_enb,
   input  logic        frame,
   output logic [15:0] val,
   output logic        write_enb,
   output logic        run,
   output logic        scan,
   output logic [15:0] gen_count,
   output logic        busy,
   output logic        overrun
);

   localparam int                SCAN_W    = $clog2(SCAN_LEN + 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_LEN - 1);

   state_t              state_q, state_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic                pending_q, pending_d;
   logic                overrun_q, overrun_d;
   logic [15:0]         gen_count_q, gen_count_d;
   logic                write_enb_q, write_enb_d;
   logic                run_q, run_d;
   logic                scan_q, scan_d;
   logic                busy_q, busy_d;
   logic                load_prev_q, load_prev_d;
   logic                step_prev_q, step_prev_d;
   logic                edge_en_q, edge_en_d;

   logic                tick;
   logic                load_edge;
   logic                step_edge;
   logic                adv_req;
   logic                scan_req;

   life_tick_timer #(
      .TICK_MAX (TICK_MAX)
   ) u_tick_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (load_edge),
      .tick  (tick)
   );

   assign val = preset_val(selector);

   // Request decode, next state, pending/overrun bookkeeping and registered strobe values.
   always_comb begin
      // edge_en_q stays low for the first cycle after reset so a level held
      // across reset release is captured as "previous" before edges count.
      load_edge = edge_en_q & load_req & ~load_prev_q;
      step_edge = edge_en_q & step_req & ~step_prev_q;
      adv_req   = step_edge | (tick & run_enb);
      scan_req  = tick & scan_enb;

      load_prev_d = load_req;
      step_prev_d = step_req;
      edge_en_d   = 1'b1;

      state_d     = state_q;
      scan_cnt_d  = scan_cnt_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      gen_count_d = gen_count_q;

      if (load_edge) begin
         // A load wins from any state and aborts whatever was in progress.
         state_d     = ST_LOAD;
         scan_cnt_d  = '0;
         pending_d   = 1'b0;
         overrun_d   = 1'b0;
         gen_count_d = 16'h0000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pending_q || adv_req) begin
                  // Step and run tick together are one advance; a new request
                  // arriving while the queued one is serviced stays queued.
                  state_d   = ST_ARMED;
                  pending_d = pending_q & adv_req;
                  if (scan_req) begin
                     overrun_d = 1'b1;
                  end
               end else if (scan_req) begin
                  state_d    = ST_SCAN;
                  scan_cnt_d = '0;
               end
            end
            ST_LOAD: begin
               state_d = ST_IDLE;
            end
            ST_ARMED: begin
               // Hold the advance until frame start so the display never tears.
               if (frame) begin
                  state_d = ST_ADVANCE;
               end
            end
            ST_ADVANCE: begin
               state_d = ST_IDLE;
            end
            ST_SCAN: begin
               if (scan_cnt_q == SCAN_LAST) begin
                  state_d    = ST_IDLE;
                  scan_cnt_d = '0;
               end else begin
                  scan_cnt_d = scan_cnt_q + SCAN_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (state_q != ST_IDLE) begin
            if (adv_req) begin
               if (pending_q) begin
                  overrun_d = 1'b1;
               end else begin
                  pending_d = 1'b1;
               end
            end
            if (scan_req) begin
               overrun_d = 1'b1;
            end
         end

         if (state_d == ST_ADVANCE) begin
            gen_count_d = gen_count_q + 16'd1;
         end
      end

      write_enb_d = (state_d == ST_LOAD);
      run_d       = (state_d == ST_ADVANCE);
      scan_d      = (state_d == ST_SCAN);
      busy_d      = (state_d != ST_IDLE);
   end

   // Request edge detectors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_prev_q <= 1'b0;
         step_prev_q <= 1'b0;
         edge_en_q   <= 1'b0;
      end else begin
         load_prev_q <= load_prev_d;
         step_prev_q <= step_prev_d;
         edge_en_q   <= edge_en_d;
      end
   end

   // Sequencer FSM with its registered strobes and status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         scan_cnt_q  <= '0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         gen_count_q <= 16'h0000;
         write_enb_q <= 1'b0;
         run_q       <= 1'b0;
         scan_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_cnt_q  <= scan_cnt_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         gen_count_q <= gen_count_d;
         write_enb_q <= write_enb_d;
         run_q       <= run_d;
         scan_q      <= scan_d;
         busy_q      <= busy_d;
      end
   end

   assign write_enb = write_enb_q;
   assign run       = run_q;
   assign scan      = scan_q;
   assign gen_count = gen_count_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_life_sequencer.sv
`timescale 1ns/1ps
// Directed bench for life_sequencer with a short tick period.
// Latency: n/a.
// Backpressure: n/a.
module tb_life_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  selector;
   logic        load_req;
   logic        step_req;
   logic        run_enb;
   logic        scan_enb;
   logic        frame;
   logic        frame_auto;
   logic        frame_man;
   logic        frame_en;
   logic [15:0] val;
   logic        write_enb;
   logic        run;
   logic        scan;
   logic [15:0] gen_count;
   logic        busy;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [3:0]  sel;
      logic [15:0] exp_val;
   } vec_t;

   vec_t vecs [9];

   assign frame = frame_auto | frame_man;

   life_sequencer #(
      .TICK_MAX (4),
      .SCAN_LEN (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .selector  (selector),
      .load_req  (load_req),
      .step_req  (step_req),
      .run_enb   (run_enb),
      .scan_enb  (scan_enb),
      .frame     (frame),
      .val       (val),
      .write_enb (write_enb),
      .run       (run),
      .scan      (scan),
      .gen_count (gen_count),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Frame generator: one-cycle pulse every 10 cycles, driven on the falling edge.
   initial begin
      int fc;
      fc = 0;
      frame_auto = 1'b0;
      forever begin
         @(negedge clk);
         if (frame_en) begin
            fc = (fc == 9) ? 0 : fc + 1;
            frame_auto = (fc == 0);
         end else begin
            fc = 0;
            frame_auto = 1'b0;
         end
      end
   end

   // Hard stop in case something hangs.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] sel);
      load_req = 1'b0;
      cyc();
      selector = sel;
      load_req = 1'b1;
      cyc();
      load_req = 1'b0;
   endtask

   task automatic step_pulse();
      step_req = 1'b1;
      cyc();
      step_req = 1'b0;
      cyc();
   endtask

   task automatic pulse_frame();
      frame_man = 1'b1;
      cyc();
      frame_man = 1'b0;
   endtask

   task automatic run_cycles(input int n, output int runs, output int scans);
      runs  = 0;
      scans = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (run)  runs++;
         if (scan) scans++;
      end
   endtask

   task automatic wait_scan(output int waited);
      waited = 0;
      while (!scan && waited < 20) begin
         cyc();
         waited++;
      end
   endtask

   initial begin
      int n_run;
      int n_scan;
      int guard;
      int cnt;
      logic prev_run;

      vecs[0] = '{4'b0000, 16'h0000};
      vecs[1] = '{4'b0001, 16'h3300};
      vecs[2] = '{4'b0010, 16'h33CC};
      vecs[3] = '{4'b0100, 16'h0600};
      vecs[4] = '{4'b1000, 16'h6286};
      vecs[5] = '{4'b0011, 16'h3300};
      vecs[6] = '{4'b0110, 16'h33CC};
      vecs[7] = '{4'b1100, 16'h0600};
      vecs[8] = '{4'b1111, 16'h3300};

      reset     = 1'b1;
      selector  = 4'b0000;
      load_req  = 1'b0;
      step_req  = 1'b0;
      run_enb   = 1'b0;
      scan_enb  = 1'b0;
      frame_man = 1'b0;
      frame_en  = 1'b0;

      // Reset state.
      #2;
      chk("rst_write_enb", write_enb, 0);
      chk("rst_run", run, 0);
      chk("rst_scan", scan, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gen_count", gen_count, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_val", val, 0);
      repeat (3) cyc();
      reset = 1'b0;
      repeat (2) cyc();

      // Preset decode table.
      for (int i = 0; i < 9; i++) begin
         selector = vecs[i].sel;
         cyc();
         chk($sformatf("val_sel_%b", vecs[i].sel), val, vecs[i].exp_val);
      end

      // Load: single write strobe with the selected preset.
      do_load(4'b0010);
      chk("load_write_enb", write_enb, 1);
      chk("load_val", val, 16'h33CC);
      chk("load_gen_count", gen_count, 0);
      chk("load_busy", busy, 1);
      chk("load_no_run_scan", {run, scan}, 0);
      cyc();
      chk("load_write_enb_one_cycle", write_enb, 0);
      chk("load_idle_after", busy, 0);

      // Auto-run: each run pulse follows a frame, gen_count 1,2,3.
      run_enb  = 1'b1;
      frame_en = 1'b1;
      n_run    = 0;
      guard    = 0;
      prev_run = 1'b0;
      while (n_run < 3 && guard < 300) begin
         cyc();
         guard++;
         if (run) begin
            n_run++;
            chk("run_on_frame", frame, 1);
            chk("run_gen_count", gen_count, n_run);
            chk("run_single_cycle", prev_run, 0);
            chk("run_exclusive", {write_enb, scan}, 0);
         end
         prev_run = run;
      end
      chk("run_pulses_seen", n_run, 3);
      run_enb  = 1'b0;
      frame_en = 1'b0;

      do_load(4'b0001);
      chk("reload_val", val, 16'h3300);
      chk("reload_gen_count", gen_count, 0);
      chk("reload_clears_overrun", overrun, 0);

      // Scan burst: 16 consecutive pulses then idle.
      do_load(4'b0000);
      scan_enb = 1'b1;
      wait_scan(guard);
      chk("scan_tick_latency", guard, 4);
      cnt = 0;
      while (scan && cnt < 40) begin
         cnt++;
         scan_enb = 1'b0;
         chk("scan_exclusive", {write_enb, run}, 0);
         cyc();
      end
      chk("scan_burst_len", cnt, 16);
      chk("scan_busy_after", busy, 0);
      chk("scan_no_overrun", overrun, 0);
      run_cycles(8, n_run, n_scan);
      chk("scan_no_extra_pulses", n_scan, 0);

      // Load on the 5th scan pulse aborts the burst.
      do_load(4'b0000);
      scan_enb = 1'b1;
      wait_scan(guard);
      chk("abort_scan_start", scan, 1);
      for (int k = 2; k <= 5; k++) begin
         cyc();
         chk($sformatf("abort_scan_pulse_%0d", k), scan, 1);
      end
      chk("abort_overrun_before_load", overrun, 1);
      load_req = 1'b1;
      scan_enb = 1'b0;
      cyc();
      load_req = 1'b0;
      chk("abort_scan_stopped", scan, 0);
      chk("abort_write_enb", write_enb, 1);
      chk("abort_overrun", overrun, 0);
      chk("abort_gen_count", gen_count, 0);
      run_cycles(20, n_run, n_scan);
      chk("abort_no_resume", n_scan, 0);

      // Three step edges while armed: two advances, overrun set.
      do_load(4'b0000);
      cyc();
      step_pulse();
      step_pulse();
      step_pulse();
      chk("armed3_overrun", overrun, 1);
      chk("armed3_busy", busy, 1);
      chk("armed3_no_advance_yet", gen_count, 0);
      pulse_frame();
      chk("armed3_run1", run, 1);
      chk("armed3_gen1", gen_count, 1);
      cyc();
      chk("armed3_run1_one_cycle", run, 0);
      cyc();
      chk("armed3_pending_rearm", busy, 1);
      run_cycles(8, n_run, n_scan);
      chk("armed3_waits_frame", n_run, 0);
      pulse_frame();
      chk("armed3_run2", run, 1);
      chk("armed3_gen2", gen_count, 2);
      run_cycles(5, n_run, n_scan);
      cnt = n_run;
      pulse_frame();
      if (run) cnt++;
      run_cycles(5, n_run, n_scan);
      cnt += n_run;
      chk("armed3_no_third_run", cnt, 0);
      chk("armed3_idle", busy, 0);
      chk("armed3_overrun_sticky", overrun, 1);

      // gen_count wrap: preload 0xFFFF, one more advance wraps to zero.
      force dut.gen_count_q = 16'hFFFF;
      cyc();
      cyc();
      release dut.gen_count_q;
      cyc();
      chk("wrap_preload", gen_count, 16'hFFFF);
      step_req = 1'b1;
      cyc();
      step_req  = 1'b0;
      frame_man = 1'b1;
      cyc();
      frame_man = 1'b0;
      chk("wrap_run", run, 1);
      chk("wrap_gen_count", gen_count, 16'h0000);
      cyc();

      // Reset while armed, step level held across release.
      selector = 4'b0000;
      step_req = 1'b1;
      cyc();
      chk("rstarm_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstarm_outputs", {val, write_enb, run, scan, busy, overrun}, 0);
      chk("rstarm_gen_count", gen_count, 0);
      cyc();
      cyc();
      reset    = 1'b0;
      frame_en = 1'b1;
      run_cycles(25, n_run, n_scan);
      chk("rstarm_no_run", n_run, 0);
      chk("rstarm_idle", busy, 0);
      step_req = 1'b0;
      frame_en = 1'b0;

      // Reset mid scan burst stops pulses at once, none after release.
      do_load(4'b0000);
      scan_enb = 1'b1;
      wait_scan(guard);
      cyc();
      cyc();
      chk("rstscan_mid_burst", scan, 1);
      #3;
      reset = 1'b1;
      #1;
      chk("rstscan_stopped", scan, 0);
      chk("rstscan_busy", busy, 0);
      scan_enb = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      run_cycles(20, n_run, n_scan);
      chk("rstscan_no_pulse", n_scan, 0);

      // Step edge coincident with a run tick gives one advance.
      do_load(4'b0000);
      run_enb = 1'b1;
      cyc();
      cyc();
      cyc();
      step_req = 1'b1;
      cyc();
      run_enb  = 1'b0;
      step_req = 1'b0;
      chk("coinc_armed", busy, 1);
      chk("coinc_no_overrun", overrun, 0);
      pulse_frame();
      chk("coinc_run", run, 1);
      chk("coinc_gen", gen_count, 1);
      run_cycles(4, n_run, n_scan);
      cnt = n_run;
      pulse_frame();
      if (run) cnt++;
      run_cycles(6, n_run, n_scan);
      cnt += n_run;
      chk("coinc_single_advance", cnt, 0);
      chk("coinc_overrun_clear", overrun, 0);
      chk("coinc_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter TICK_MAX, default 100000000, clk cycles per auto-run tick (min 2).
REQ-002 Parameter SCAN_LEN, default 16, scan pulses per scan burst (cells in the 4x4 array).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 selector  in  4  preset select (bit0 highest priority).
REQ-006 load_req  in  1  level from button; rising edge requests preset load.
REQ-007 step_req  in  1  level; rising edge requests a single generation.
REQ-008 run_enb  in  1  level; enables auto-run on every tick.
REQ-009 scan_enb  in  1  level; enables a scan burst on every tick.
REQ-010 frame  in  1  one-cycle frame-start pulse from the VESA driver.
REQ-011 val  out  16  preset pattern to the array.
REQ-012 write_enb  out  1  one-cycle array load strobe.
REQ-013 run  out  1  one-cycle generation-advance strobe.
REQ-014 scan  out  1  scan shift strobe.
REQ-015 gen_count  out  16  generations since last load.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 overrun  out  1  sticky: a request was dropped.

Function
REQ-018 val SHALL be combinational from selector: bit0 -> 16'h3300, bit1 -> 16'h33CC, bit2 -> 16'h0600, bit3 -> 16'h6286, none -> 16'h0000.
REQ-019 load_req and step_req SHALL be rising-edge detected with one register; an edge is a request for one cycle.
REQ-020 Tick counter SHALL count 0..TICK_MAX-1 and assert tick for one cycle on wrap; it SHALL clear on a load.
REQ-021 States: IDLE, LOAD, ARMED, ADVANCE, SCAN.
REQ-022 IDLE: load edge -> LOAD; else step edge or (tick and run_enb) -> ARMED; else tick and scan_enb -> SCAN.
REQ-023 LOAD: write_enb=1 for exactly one cycle, gen_count cleared to 0, pending cleared -> IDLE.
REQ-024 ARMED: wait for frame; on the cycle frame=1 -> ADVANCE (display never changes mid-frame).
REQ-025 ADVANCE: run=1 for exactly one cycle, gen_count increments by 1 modulo 2^16 (0xFFFF -> 0x0000) -> IDLE.
REQ-026 SCAN: scan=1 on SCAN_LEN consecutive cycles counted by a scan counter, then -> IDLE.
REQ-027 Outputs write_enb, run, scan SHALL be registered (state-decoded from registers), mutually exclusive, never two high in one cycle.
REQ-028 Load edge in ARMED or SCAN SHALL abort that operation, next state LOAD; a scan aborted mid-burst does not resume.
REQ-029 Step edge or run tick while ARMED, ADVANCE or SCAN SHALL set one pending-advance flag; IDLE services pending before new scan ticks; a second request while pending set SHALL be dropped and set overrun.
REQ-030 Scan tick while not IDLE SHALL be dropped and set overrun.
REQ-031 Simultaneous step edge and run tick in IDLE SHALL produce one advance only.
REQ-032 overrun SHALL clear only on reset or load.
REQ-033 gen_count width fixed at 16 bits; no saturation.

Reset
REQ-034 Reset SHALL immediately force state IDLE, tick counter 0, scan counter 0, pending 0, edge registers 0, gen_count 0, overrun 0, write_enb/run/scan 0, busy 0.
REQ-035 Reset asserted mid-burst SHALL stop scan pulses in the same cycle; no pulse on release.
REQ-036 A level held high on load_req/step_req across reset release SHALL not produce an edge.

Structure
REQ-037 Shared package SHALL hold the state encoding, the four preset constants and SCAN_LEN default.
REQ-038 One sub-module, life_tick_timer (parameterised counter emitting tick), is natural; the FSM stays in life_sequencer.

Verification
REQ-039 TICK_MAX=4, selector=4'b0010, load edge -> write_enb one cycle, val=16'h33CC, gen_count=0.
REQ-040 run_enb=1, frame every 10 cycles -> each tick yields one run pulse on the cycle after frame; gen_count 1,2,3.
REQ-041 scan_enb=1, run_enb=0, tick -> exactly 16 consecutive scan pulses, then busy=0.
REQ-042 Load edge on 5th scan pulse -> scan stops, write_enb next cycle, overrun=0, gen_count=0.
REQ-043 Three step edges while ARMED awaiting frame -> two run pulses total, overrun=1.
REQ-044 gen_count preloaded to 0xFFFF via 65535 steps, one more step -> gen_count=0x0000; reset mid-ARMED -> all outputs 0, no run after release.
